// File: rtl/angle_reducer_pkg.sv
// Shared constants for the angle front ends: full turn, reduction
// step count and FSM state encoding.
package angle_reducer_pkg;

    localparam int unsigned DEG_FULL = 360;
    localparam int unsigned STEPS    = 24;
    localparam int unsigned K_W      = 5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REDUCE = 2'd1;
    localparam logic [1:0] ST_MAP    = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/angle_reducer_quadrant_fold.sv
// Folds a reduced angle 0..359 into quadrant, 0..90 reference
// angle and a pole flag for the tangent LUT.
module quadrant_fold (
    input  logic [8:0] a,
    output logic [1:0] quadrant,
    output logic [8:0] ref_angle,
    output logic       pole
);

    always_comb begin
        quadrant  = 2'd0;
        ref_angle = a;
        unique case (1'b1)
            (a < 9'd90): begin
                quadrant  = 2'd0;
                ref_angle = a;
            end
            (a >= 9'd90 && a < 9'd180): begin
                quadrant  = 2'd1;
                ref_angle = 9'd180 - a;
            end
            (a >= 9'd180 && a < 9'd270): begin
                quadrant  = 2'd2;
                ref_angle = a - 9'd180;
            end
            (a >= 9'd270): begin
                quadrant  = 2'd3;
                ref_angle = 9'd360 - a;
            end
            default: ;
        endcase
    end

    assign pole = (a == 9'd90) || (a == 9'd270);

endmodule

// File: rtl/angle_reducer.sv
// Reduces an unsigned degree angle modulo 360 by shift-subtract,
// then folds it into quadrant + reference angle for the tangent LUT.
module angle_reducer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_angle,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] ref_angle,
    output logic [1:0]            quadrant,
    output logic                  pole,
    output logic                  out_valid,
    input  logic                  out_ready
);
    import angle_reducer_pkg::*;

    localparam int WW = DATA_WIDTH + 9;

    logic [1:0]            state_q, state_d;
    logic [K_W-1:0]        k_q, k_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic [DATA_WIDTH-1:0] ref_angle_q, ref_angle_d;
    logic [1:0]            quadrant_q, quadrant_d;
    logic                  pole_q, pole_d;
    logic                  out_valid_q, out_valid_d;

    // Wide compare so 360 << 23 cannot wrap at DATA_WIDTH bits
    logic [WW-1:0] rem_w, sub_w, diff_w;
    assign rem_w  = {9'd0, rem_q};
    assign sub_w  = WW'(DEG_FULL) << k_q;
    assign diff_w = rem_w - sub_w;

    logic [1:0] fold_quadrant;
    logic [8:0] fold_ref;
    logic       fold_pole;

    quadrant_fold u_fold (
        .a         (rem_q[8:0]),
        .quadrant  (fold_quadrant),
        .ref_angle (fold_ref),
        .pole      (fold_pole)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        rem_d       = rem_q;
        ref_angle_d = ref_angle_q;
        quadrant_d  = quadrant_q;
        pole_d      = pole_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    rem_d   = in_angle;
                    k_d     = K_W'(STEPS - 1);
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (rem_w >= sub_w) begin
                    rem_d = diff_w[DATA_WIDTH-1:0];
                end
                if (k_q == '0) begin
                    state_d = ST_MAP;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            ST_MAP: begin
                ref_angle_d = DATA_WIDTH'(fold_ref);
                quadrant_d  = fold_quadrant;
                pole_d      = fold_pole;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            rem_q       <= '0;
            ref_angle_q <= '0;
            quadrant_q  <= 2'd0;
            pole_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            rem_q       <= rem_d;
            ref_angle_q <= ref_angle_d;
            quadrant_q  <= quadrant_d;
            pole_q      <= pole_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign ref_angle = ref_angle_q;
    assign quadrant  = quadrant_q;
    assign pole      = pole_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_angle_reducer.sv
// Directed bench for angle_reducer: latency, folding, back-pressure
// and mid-reduction reset.
module tb_angle_reducer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_angle;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ref_angle;
    logic [1:0]  quadrant;
    logic        pole;
    logic        out_valid;
    logic        out_ready;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    angle_reducer #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_angle  (in_angle),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ref_angle (ref_angle),
        .quadrant  (quadrant),
        .pole      (pole),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_out(output int n);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_angle(input logic [31:0] ang, input logic [1:0] q,
                             input logic [31:0] r, input logic p,
                             input string tag);
        int n;
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        in_angle = ang;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_angle = 32'hDEAD_BEEF;
        wait_out(n);
        check({tag, " latency"}, n, 25);
        check({tag, " quadrant"}, {30'd0, quadrant}, {30'd0, q});
        check({tag, " ref"}, ref_angle, r);
        check({tag, " pole"}, {31'd0, pole}, {31'd0, p});
        @(posedge clk); #1;
        check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int  n;
        logic seen;
        reset     = 1'b1;
        in_angle  = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst ref", ref_angle, 32'd0);
        check("rst quadrant", {30'd0, quadrant}, 32'd0);
        check("rst pole", {31'd0, pole}, 32'd0);

        run_angle(32'd45,  2'd0, 32'd45, 1'b0, "a45");
        run_angle(32'd135, 2'd1, 32'd45, 1'b0, "a135");
        run_angle(32'd225, 2'd2, 32'd45, 1'b0, "a225");
        run_angle(32'd315, 2'd3, 32'd45, 1'b0, "a315");
        run_angle(32'd90,  2'd1, 32'd90, 1'b1, "a90");
        run_angle(32'd270, 2'd3, 32'd90, 1'b1, "a270");
        run_angle(32'd0,   2'd0, 32'd0,  1'b0, "a0");
        run_angle(32'd360, 2'd0, 32'd0,  1'b0, "a360");
        run_angle(32'hFFFF_FFFF, 2'd2, 32'd75, 1'b0, "amax");
        run_angle(32'd179, 2'd1, 32'd1,  1'b0, "a179");
        run_angle(32'd180, 2'd2, 32'd0,  1'b0, "a180");
        run_angle(32'd359, 2'd3, 32'd1,  1'b0, "a359");
        run_angle(32'd721, 2'd0, 32'd1,  1'b0, "a721");

        // back-pressure with a competing request
        out_ready = 1'b0;
        in_angle  = 32'd1000;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(n);
        check("bp latency", n, 25);
        in_angle = 32'd45;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp valid", {31'd0, out_valid}, 32'd1);
            check("bp quadrant", {30'd0, quadrant}, 32'd3);
            check("bp ref", ref_angle, 32'd80);
            check("bp pole", {31'd0, pole}, 32'd0);
            check("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs in_ready", {31'd0, in_ready}, 32'd1);
        check("hs out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("acc2 in_ready", {31'd0, in_ready}, 32'd0);
        wait_out(n);
        check("acc2 latency", n, 25);
        check("acc2 quadrant", {30'd0, quadrant}, 32'd0);
        check("acc2 ref", ref_angle, 32'd45);
        @(posedge clk); #1;

        // reset at E10 of a reduction
        in_angle = 32'd225;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid rst in_ready", {31'd0, in_ready}, 32'd1);
        check("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mid rst no pulse", {31'd0, seen}, 32'd0);
        run_angle(32'd135, 2'd1, 32'd45, 1'b0, "post rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/angle_reducer.md
# angle_reducer

Front-end range reducer for the trigonometric datapath. It accepts an unsigned integer angle in degrees of any magnitude and reduces it modulo 360 with a fixed-latency shift-subtract sequence. It then folds the result into a 0–90° reference angle plus a 2-bit quadrant, which is exactly what `tangent_LUT` consumes on `data_in` and `quadrant`. `out_valid` drives the LUT's `en_tangent`.

## Interface
Parameters:
- `DATA_WIDTH` (from `src/defines.v`, 32): angle width. The reduction step count is fixed for 32 bits.
- `STEPS`, localparam 24: shift-subtract iterations. 360·2^24 > 2^32 − 1.

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_angle`  in  DATA_WIDTH  unsigned angle in degrees
- `in_valid`  in  1  `in_angle` is valid
- `in_ready`  out  1  block can accept a new angle
- `ref_angle`  out  DATA_WIDTH  folded reference angle, 0..90
- `quadrant`  out  2  quadrant 0..3 of `in_angle mod 360`
- `pole`  out  1  reduced angle is 90 or 270 (tangent undefined)
- `out_valid`  out  1  result valid; connect to `en_tangent`
- `out_ready`  in  1  downstream accepts the result

## Operation
FSM states: IDLE → REDUCE → MAP → DONE → IDLE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid && in_ready`, latch `in_angle` into remainder register `rem` and set step counter `k` = 23. Go to REDUCE.
- **REDUCE**, one step per cycle:
  - If `rem >= (360 << k)`, then `rem <= rem - (360 << k)`.
  - Compare and subtract are done at DATA_WIDTH+9 bits so the shifted constant never overflows.
  - When `k` = 0 the step executes and the FSM goes to MAP. Otherwise `k` decrements.
- **MAP**: `a = rem`, where 0 ≤ a < 360. Register the outputs:
  - a < 90: `quadrant` = 0, `ref_angle` = a
  - 90 ≤ a < 180: `quadrant` = 1, `ref_angle` = 180 − a
  - 180 ≤ a < 270: `quadrant` = 2, `ref_angle` = a − 180
  - 270 ≤ a < 360: `quadrant` = 3, `ref_angle` = 360 − a
  - `pole` = (a == 90 || a == 270).
  - Go to DONE.
- **DONE**
  - `out_valid` = 1. Outputs are held stable until `out_ready`.
  - On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- `in_valid` is ignored outside IDLE. There is no queueing and no input is lost, because `in_ready` = 0 in those states.
- Because the angle is a 2-bit quadrant plus a 0–90 reference, `ref_angle` never exceeds 90.

## Timing
- `in_ready` = (state == IDLE) is combinational from the state register.
- Latency: the accept edge is E0. REDUCE occupies edges E1..E24 and MAP executes at E25. `out_valid` is high from the cycle after E25, so the result is 25 cycles after acceptance.
- Minimum initiation interval is 27 cycles with `out_ready` tied high: 1 accept, 24 reduce, 1 map, 1 done.
- Reset, taken at any state:
  - State → IDLE, `k` = 0, `rem` = 0.
  - `ref_angle` = 0, `quadrant` = 0, `pole` = 0, `out_valid` = 0.
  - `in_ready` reads 1 in the first cycle after the reset edge.
  - Reset mid-REDUCE or in DONE discards the in-flight angle. No `out_valid` pulse follows.
- Back-pressure: while DONE and `out_ready` = 0, all outputs are constant cycle to cycle.
- `in_angle` is sampled only on the accept edge. Later changes have no effect.

## Structure
- The constant 360, `STEPS`, and the state encoding (IDLE = 2'd0, REDUCE = 2'd1, MAP = 2'd2, DONE = 2'd3) go in `src/defines.v` as macros, for reuse by the sine/cosine front ends.
- Sub-module `quadrant_fold`: combinational a → {quadrant, ref_angle, pole}, registered by the parent in MAP.
- Expected size is about 150–200 lines of RTL.

## Test plan
- Inputs 45, 135, 225, 315, each with `out_ready` = 1 → quadrant 0/1/2/3, `ref_angle` = 45 for all, `pole` = 0, `out_valid` exactly 25 cycles after each accept.
- Inputs 90, 270, 0, 360 → (q1, 90, pole = 1), (q3, 90, pole = 1), (q0, 0, pole = 0), (q0, 0, pole = 0).
- Input 32'hFFFF_FFFF (mod 360 = 255) → quadrant 2, `ref_angle` 75. Input 32'd1000 (mod 360 = 280) → quadrant 3, `ref_angle` 80.
- Hold `out_ready` = 0 for 5 cycles after `out_valid` → outputs stable, `in_ready` = 0. Drive a second `in_valid` meanwhile → it is not accepted until the cycle after the `out_ready` handshake.
- Assert `reset` for one cycle at E10 of a reduction → `out_valid` never rises for that angle, `in_ready` = 1 next cycle, and a fresh 135 completes normally.
- Connect to `tangent_LUT` and sweep 0..359 → LUT output matches the golden tan value for every non-pole angle.
